// File: rtl/dcmac_0_axis_pkt_mon_ts.sv
// dcmac_0_axis_pkt_mon_ts: RX segmented-bus monitor with per-ID framing, length and payload counters.
// Optional sticky error flags are built when DCMAC_0_PKT_MON_STICKY_EN is defined.
module dcmac_0_axis_pkt_mon_ts #(
  parameter int COUNTER_MODE = 0,
  parameter int NUM_ID       = 6,
  localparam int ID_W = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic [ID_W-1:0]         i_id,
  input  logic [11:0]             i_ena,
  input  logic [11:0]             i_sop,
  input  logic [11:0]             i_eop,
  input  logic [11:0]             i_err,
  input  logic [11:0][3:0]        i_mty,
  input  logic [11:0][127:0]      i_dat,
  input  logic [15:0]             i_min_len,
  input  logic [15:0]             i_max_len,
  input  logic [NUM_ID-1:0]       i_clear_counters,
  output logic [NUM_ID-1:0][63:0] o_byte_cnt,
  output logic [NUM_ID-1:0][63:0] o_pkt_cnt,
  output logic [NUM_ID-1:0][31:0] o_err_pkt_cnt,
  output logic [NUM_ID-1:0][31:0] o_len_err_cnt,
  output logic [NUM_ID-1:0][31:0] o_frm_err_cnt,
  output logic [NUM_ID-1:0][31:0] o_dat_err_cnt,
  output logic [NUM_ID-1:0]       o_sticky_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} st_e;

  logic                    vld_q, vld_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [11:0]             ena_q, ena_d, sop_q, sop_d;
  logic [11:0]             eop_q, eop_d, err_q, err_d;
  logic [11:0][3:0]        mty_q, mty_d;
  logic [11:0][127:0]      dat_q, dat_d;
  logic [15:0]             min_q, min_d, max_q, max_d;
  logic [NUM_ID-1:0]       clr_q, clr_d;

  st_e  [NUM_ID-1:0]       state_q, state_d;
  logic [NUM_ID-1:0][15:0] len_q, len_d;
  logic [NUM_ID-1:0][7:0]  ctx_q, ctx_d;
  logic [NUM_ID-1:0]       seed_q, seed_d;
  logic [NUM_ID-1:0][63:0] byte_cnt_q, byte_cnt_d;
  logic [NUM_ID-1:0][63:0] pkt_cnt_q, pkt_cnt_d;
  logic [NUM_ID-1:0][31:0] errp_cnt_q, errp_cnt_d;
  logic [NUM_ID-1:0][31:0] len_cnt_q, len_cnt_d;
  logic [NUM_ID-1:0][31:0] frm_cnt_q, frm_cnt_d;
  logic [NUM_ID-1:0][31:0] dat_cnt_q, dat_cnt_d;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
  logic [NUM_ID-1:0]       sticky_q, sticky_d;
`endif

  function automatic logic [31:0] sat32(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {29'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Stage 1: capture the bus word, limits and clear request together.
  always_comb begin
    vld_d = i_vld;
    id_d  = i_id;
    ena_d = i_ena;
    sop_d = i_sop;
    eop_d = i_eop;
    err_d = i_err;
    mty_d = i_mty;
    dat_d = i_dat;
    min_d = i_min_len;
    max_d = i_max_len;
    clr_d = i_clear_counters;
  end

  // State register for both stages; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= 1'b0;
      id_q       <= '0;
      ena_q      <= '0;
      sop_q      <= '0;
      eop_q      <= '0;
      err_q      <= '0;
      mty_q      <= '0;
      dat_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      clr_q      <= '0;
      for (int n = 0; n < NUM_ID; n++) state_q[n] <= ST_IDLE;
      len_q      <= '0;
      ctx_q      <= '0;
      seed_q     <= '0;
      byte_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      errp_cnt_q <= '0;
      len_cnt_q  <= '0;
      frm_cnt_q  <= '0;
      dat_cnt_q  <= '0;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
      sticky_q   <= '0;
`endif
    end else begin
      vld_q      <= vld_d;
      id_q       <= id_d;
      ena_q      <= ena_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      mty_q      <= mty_d;
      dat_q      <= dat_d;
      min_q      <= min_d;
      max_q      <= max_d;
      clr_q      <= clr_d;
      state_q    <= state_d;
      len_q      <= len_d;
      ctx_q      <= ctx_d;
      seed_q     <= seed_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      errp_cnt_q <= errp_cnt_d;
      len_cnt_q  <= len_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
      sticky_q   <= sticky_d;
`endif
    end
  end

  logic            hit;
  logic [ID_W-1:0] k;
  st_e             st;
  logic [15:0]     len;
  logic [7:0]      ctx, b;
  logic            seed, take, derr;
  logic [4:0]      sb;
  logic [7:0]      nb;
  logic [3:0]      npk, nep, nle, nfe;

  // Stage 2: walk segments 0..11 through the ID's framing FSM, then apply clears.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ctx_d      = ctx_q;
    seed_d     = seed_q;
    byte_cnt_d = byte_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    errp_cnt_d = errp_cnt_q;
    len_cnt_d  = len_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    dat_cnt_d  = dat_cnt_q;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
    sticky_d   = sticky_q;
`endif
    hit  = vld_q && (int'(id_q) < NUM_ID);
    k    = hit ? id_q : '0;
    st   = state_q[k];
    len  = len_q[k];
    ctx  = ctx_q[k];
    seed = seed_q[k];
    take = 1'b0;
    derr = 1'b0;
    sb   = '0;
    b    = '0;
    nb   = '0;
    npk  = '0;
    nep  = '0;
    nle  = '0;
    nfe  = '0;
    for (int i = 0; i < 12; i++) begin
      if (hit && ena_q[4'(i)]) begin
        sb   = eop_q[4'(i)] ? 5'd16 - {1'b0, mty_q[4'(i)]} : 5'd16;
        take = 1'b0;
        if (sop_q[4'(i)]) begin
          if (st == ST_IN_PKT) nfe = nfe + 4'd1;
          st   = ST_IN_PKT;
          len  = {11'd0, sb};
          take = 1'b1;
        end else if (st == ST_IN_PKT) begin
          len  = sat16(len, sb);
          take = 1'b1;
        end else begin
          nfe  = nfe + 4'd1;
        end
        if (take) begin
          nb = nb + {3'd0, sb};
          if (COUNTER_MODE != 0) begin
            for (int j = 0; j < 16; j++) begin
              if (5'(j) < sb) begin
                b = dat_q[4'(i)][7'(8*j) +: 8];
                if (seed && (b != ctx)) derr = 1'b1;
                ctx  = b + 8'd1;
                seed = 1'b1;
              end
            end
          end
        end
        if (eop_q[4'(i)]) begin
          npk = npk + 4'd1;
          if (err_q[4'(i)]) nep = nep + 4'd1;
          if (take && ((len < min_q) || (len > max_q))) nle = nle + 4'd1;
          st = ST_IDLE;
        end
      end
    end
    if (hit) begin
      state_d[k]    = st;
      len_d[k]      = len;
      ctx_d[k]      = ctx;
      seed_d[k]     = seed;
      byte_cnt_d[k] = byte_cnt_q[k] + {56'd0, nb};
      pkt_cnt_d[k]  = pkt_cnt_q[k] + {60'd0, npk};
      errp_cnt_d[k] = sat32(errp_cnt_q[k], nep);
      len_cnt_d[k]  = sat32(len_cnt_q[k], nle);
      frm_cnt_d[k]  = sat32(frm_cnt_q[k], nfe);
      dat_cnt_d[k]  = sat32(dat_cnt_q[k], {3'd0, derr});
`ifdef DCMAC_0_PKT_MON_STICKY_EN
      if ((nep != 0) || (nle != 0) || (nfe != 0) || derr) sticky_d[k] = 1'b1;
`endif
    end
    for (int n = 0; n < NUM_ID; n++) begin
      if (clr_q[ID_W'(n)]) begin
        state_d[ID_W'(n)]    = ST_IDLE;
        len_d[ID_W'(n)]      = '0;
        ctx_d[ID_W'(n)]      = '0;
        seed_d[ID_W'(n)]     = 1'b0;
        byte_cnt_d[ID_W'(n)] = '0;
        pkt_cnt_d[ID_W'(n)]  = '0;
        errp_cnt_d[ID_W'(n)] = '0;
        len_cnt_d[ID_W'(n)]  = '0;
        frm_cnt_d[ID_W'(n)]  = '0;
        dat_cnt_d[ID_W'(n)]  = '0;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
        sticky_d[ID_W'(n)]   = 1'b0;
`endif
      end
    end
  end

  // Drive the status outputs straight from the counter registers.
  always_comb begin
    o_byte_cnt    = byte_cnt_q;
    o_pkt_cnt     = pkt_cnt_q;
    o_err_pkt_cnt = errp_cnt_q;
    o_len_err_cnt = len_cnt_q;
    o_frm_err_cnt = frm_cnt_q;
    o_dat_err_cnt = dat_cnt_q;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
    o_sticky_err  = sticky_q;
`else
    o_sticky_err  = '0;
`endif
  end

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_ts.sv
// tb_dcmac_0_axis_pkt_mon_ts: scoreboard bench for the packet monitor.
// Expected per-ID counters are queued with each word and compared two cycles later.
module tb_dcmac_0_axis_pkt_mon_ts;

  localparam int NID = 6;
`ifdef DCMAC_0_PKT_MON_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_vld;
  logic [2:0]           i_id;
  logic [11:0]          i_ena, i_sop, i_eop, i_err;
  logic [11:0][3:0]     i_mty;
  logic [11:0][127:0]   i_dat;
  logic [15:0]          i_min_len, i_max_len;
  logic [NID-1:0]       i_clr;
  logic [NID-1:0][63:0] o_byte_cnt, o_pkt_cnt;
  logic [NID-1:0][31:0] o_err_pkt_cnt, o_len_err_cnt;
  logic [NID-1:0][31:0] o_frm_err_cnt, o_dat_err_cnt;
  logic [NID-1:0]       o_sticky_err;

  dcmac_0_axis_pkt_mon_ts #(
    .COUNTER_MODE(1),
    .NUM_ID(NID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_vld(i_vld),
    .i_id(i_id),
    .i_ena(i_ena),
    .i_sop(i_sop),
    .i_eop(i_eop),
    .i_err(i_err),
    .i_mty(i_mty),
    .i_dat(i_dat),
    .i_min_len(i_min_len),
    .i_max_len(i_max_len),
    .i_clear_counters(i_clr),
    .o_byte_cnt(o_byte_cnt),
    .o_pkt_cnt(o_pkt_cnt),
    .o_err_pkt_cnt(o_err_pkt_cnt),
    .o_len_err_cnt(o_len_err_cnt),
    .o_frm_err_cnt(o_frm_err_cnt),
    .o_dat_err_cnt(o_dat_err_cnt),
    .o_sticky_err(o_sticky_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] bc, pc;
    logic [31:0] ep, le, fe, de;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("byte[%0d]", e.id), o_byte_cnt[e.id], e.bc);
      chk($sformatf("pkt[%0d]", e.id), o_pkt_cnt[e.id], e.pc);
      chk($sformatf("errp[%0d]", e.id), 64'(o_err_pkt_cnt[e.id]), 64'(e.ep));
      chk($sformatf("len[%0d]", e.id), 64'(o_len_err_cnt[e.id]), 64'(e.le));
      chk($sformatf("frm[%0d]", e.id), 64'(o_frm_err_cnt[e.id]), 64'(e.fe));
      chk($sformatf("dat[%0d]", e.id), 64'(o_dat_err_cnt[e.id]), 64'(e.de));
    end
  end

  task automatic blank();
    i_vld     = 1'b0;
    i_id      = '0;
    i_ena     = '0;
    i_sop     = '0;
    i_eop     = '0;
    i_err     = '0;
    i_mty     = '0;
    i_dat     = '0;
    i_min_len = 16'd1;
    i_max_len = 16'd9000;
    i_clr     = '0;
  endtask

  task automatic seg(input int i, input bit s, input bit eo,
                     input logic [3:0] m, input bit er);
    i_ena[i] = 1'b1;
    i_sop[i] = s;
    i_eop[i] = eo;
    i_mty[i] = m;
    i_err[i] = er;
  endtask

  task automatic fillb(input int lo, input int hi, input logic [7:0] st,
                       output logic [7:0] nx);
    logic [7:0] v;
    v = st;
    for (int p = lo; p < hi; p++) begin
      i_dat[p/16][(p%16)*8 +: 8] = v;
      v = v + 8'd1;
    end
    nx = v;
  endtask

  task automatic word(input logic [2:0] id, input logic [63:0] bc, input logic [63:0] pc,
                      input logic [31:0] ep, input logic [31:0] le,
                      input logic [31:0] fe, input logic [31:0] de);
    exp_t x;
    i_vld = 1'b1;
    i_id  = id;
    x.id = id; x.bc = bc; x.pc = pc;
    x.ep = ep; x.le = le; x.fe = fe; x.de = de;
    x.due = cyc + 2;
    sb.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    blank();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  logic [7:0] nx;

  initial begin
    blank();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NID; k++) begin
      chk($sformatf("rst_byte[%0d]", k), o_byte_cnt[k], 64'd0);
      chk($sformatf("rst_pkt[%0d]", k), o_pkt_cnt[k], 64'd0);
      chk($sformatf("rst_frm[%0d]", k), 64'(o_frm_err_cnt[k]), 64'd0);
    end
    chk("rst_sticky", 64'(o_sticky_err), 64'd0);

    // ID0: data outside a packet, then an errored single-segment packet
    @(negedge clk); blank();
    seg(0, 0, 0, 0, 0); fillb(0, 16, 8'h00, nx);
    word(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); blank();
    seg(0, 1, 1, 0, 1); fillb(0, 16, 8'h20, nx);
    word(0, 16, 1, 1, 0, 1, 0);
    drain();
    chk("sticky_id0", 64'(o_sticky_err), STK ? 64'h01 : 64'h00);

    // ID1: one clean 16B packet
    @(negedge clk); blank();
    seg(0, 1, 1, 0, 0); fillb(0, 16, 8'h00, nx);
    word(1, 16, 1, 0, 0, 0, 0);
    // ID2: 64B packet, then a continuing packet, then a restart with mty=8 and err
    @(negedge clk); blank();
    seg(0, 1, 0, 0, 0); seg(1, 0, 0, 0, 0); seg(2, 0, 0, 0, 0); seg(3, 0, 1, 0, 0);
    fillb(0, 64, 8'h00, nx);
    word(2, 64, 1, 0, 0, 0, 0);
    @(negedge clk); blank();
    seg(0, 1, 1, 0, 0); fillb(0, 16, 8'h40, nx);
    word(2, 80, 2, 0, 0, 0, 0);
    @(negedge clk); blank();
    seg(0, 1, 1, 4'd8, 1); fillb(0, 16, 8'h00, nx);
    word(2, 88, 3, 1, 0, 0, 1);
    // ID3: 65B packet against min=max=64
    @(negedge clk); blank();
    for (int s = 0; s < 5; s++) seg(s, s == 0, s == 4, (s == 4) ? 4'd15 : 4'd0, 0);
    fillb(0, 80, 8'h00, nx);
    i_min_len = 16'd64; i_max_len = 16'd64;
    word(3, 65, 1, 0, 1, 0, 0);
    // ID4: sop inside a packet, second packet completes
    @(negedge clk); blank();
    seg(0, 1, 0, 0, 0); seg(1, 0, 0, 0, 0); seg(2, 1, 0, 0, 0); seg(3, 0, 1, 0, 0);
    fillb(0, 64, 8'h00, nx);
    word(4, 64, 1, 0, 0, 1, 0);
    // ID5: 4-word stream, byte 5 of word 3 corrupted to 0xAA, stream resumes at 0xAB
    @(negedge clk); blank();
    for (int s = 0; s < 12; s++) seg(s, s == 0, 0, 0, 0);
    fillb(0, 192, 8'h10, nx);
    word(5, 192, 0, 0, 0, 0, 0);
    @(negedge clk); blank();
    for (int s = 0; s < 12; s++) seg(s, 0, 0, 0, 0);
    fillb(0, 192, nx, nx);
    word(5, 384, 0, 0, 0, 0, 0);
    @(negedge clk); blank();
    for (int s = 0; s < 12; s++) seg(s, 0, 0, 0, 0);
    fillb(0, 5, nx, nx);
    i_dat[0][47:40] = 8'hAA;
    fillb(6, 192, 8'hAB, nx);
    word(5, 576, 0, 0, 0, 0, 1);
    @(negedge clk); blank();
    for (int s = 0; s < 12; s++) seg(s, 0, s == 11, 0, 0);
    fillb(0, 192, nx, nx);
    word(5, 768, 1, 0, 0, 0, 1);
    // out-of-range ID must be ignored
    @(negedge clk); blank();
    seg(0, 0, 1, 0, 1); fillb(0, 16, 8'h00, nx);
    i_vld = 1'b1; i_id = 3'd6;
    // clear ID1 together with an eop for ID1
    @(negedge clk); blank();
    seg(0, 1, 1, 0, 1); fillb(0, 16, 8'h50, nx);
    i_clr = 6'b000010;
    word(1, 0, 0, 0, 0, 0, 0);
    drain();
    chk("keep_byte2", o_byte_cnt[2], 64'd88);
    chk("keep_pkt2", o_pkt_cnt[2], 64'd3);
    chk("keep_dat2", 64'(o_dat_err_cnt[2]), 64'd1);
    chk("keep_byte5", o_byte_cnt[5], 64'd768);
    chk("keep_byte0", o_byte_cnt[0], 64'd16);
    chk("keep_frm0", 64'(o_frm_err_cnt[0]), 64'd1);

    // ID1 context is unseeded after clear: any start value is accepted
    @(negedge clk); blank();
    seg(0, 1, 1, 0, 0); fillb(0, 16, 8'h77, nx);
    word(1, 16, 1, 0, 0, 0, 0);
    drain();
    chk("sticky_all", 64'(o_sticky_err), STK ? 64'h3D : 64'h00);

    @(negedge clk); blank();
    i_clr = 6'b000001;
    @(negedge clk); blank();
    repeat (2) @(negedge clk);
    chk("clr0_byte", o_byte_cnt[0], 64'd0);
    chk("clr0_errp", 64'(o_err_pkt_cnt[0]), 64'd0);
    chk("clr0_sticky", 64'(o_sticky_err), STK ? 64'h3C : 64'h00);

    // reset in the middle of an ID4 packet
    @(negedge clk); blank();
    seg(0, 1, 0, 0, 0); fillb(0, 16, 8'h00, nx);
    i_vld = 1'b1; i_id = 3'd4;
    @(negedge clk); blank();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NID; k++) begin
      chk($sformatf("rst2_byte[%0d]", k), o_byte_cnt[k], 64'd0);
      chk($sformatf("rst2_dat[%0d]", k), 64'(o_dat_err_cnt[k]), 64'd0);
    end
    chk("rst2_sticky", 64'(o_sticky_err), 64'd0);
    @(negedge clk); blank();
    seg(0, 1, 1, 0, 0); fillb(0, 16, 8'h30, nx);
    word(4, 16, 1, 0, 0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
